// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the CPU / loader memory port arbiter.
// The FSM encoding and default burst limit live here so the counter and top agree.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_CPU     = 2'd0,
        ARB_LD      = 2'd1,
        ARB_HOLDOFF = 2'd2
    } arb_state_t;

    localparam int unsigned MAX_BURST_DEFAULT = 4;
    localparam int unsigned CNT_W             = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the core, the loader, the external memory and the arbiter.
// slave = arbiter view, master = surrounding system view.
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
);
    logic [AW-1:0] cpu_adr;
    logic          cpu_we;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_boundary;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;

    logic          ld_req;
    logic          ld_we;
    logic [AW-1:0] ld_adr;
    logic [DW-1:0] ld_wdata;
    logic          ld_gnt;
    logic [DW-1:0] ld_rdata;

    logic [AW-1:0] mem_adr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          owner;

    modport slave (
        input  cpu_adr, cpu_we, cpu_wdata, cpu_boundary,
        input  ld_req, ld_we, ld_adr, ld_wdata,
        input  mem_rdata,
        output cpu_rdata, cpu_stall, ld_gnt, ld_rdata,
        output mem_adr, mem_we, mem_wdata, owner
    );

    modport master (
        output cpu_adr, cpu_we, cpu_wdata, cpu_boundary,
        output ld_req, ld_we, ld_adr, ld_wdata,
        output mem_rdata,
        input  cpu_rdata, cpu_stall, ld_gnt, ld_rdata,
        input  mem_adr, mem_we, mem_wdata, owner
    );

endinterface

// File: rtl/mem_port_arbiter_burst_counter.sv
// Counts granted loader beats; term_o flags the beat that brings the count to MAX_BURST,
// so the FSM can leave the loader state on that same edge.
module burst_counter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = MAX_BURST_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic term_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign term_o = en_i && (count_q == CNT_W'(MAX_BURST - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between the CPU core and a loader master.
// Ownership changes only at instruction boundaries; loader bursts are capped for fairness.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW        = 8,
    parameter int unsigned DW        = 8,
    parameter int unsigned MAX_BURST = MAX_BURST_DEFAULT
) (
    input  logic               ph1,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);

    arb_state_t    state_q;
    arb_state_t    state_d;
    logic          owner_q;
    logic [DW-1:0] ld_rdata_q;

    logic          ld_gnt;
    logic          burst_term;
    logic          burst_clr;
    logic [AW-1:0] mux_adr;
    logic [DW-1:0] mux_wdata;
    logic          mux_we;

    assign ld_gnt    = (state_q == ARB_LD) && bus.ld_req;
    assign burst_clr = (state_q == ARB_LD) && (!bus.ld_req || burst_term);

    burst_counter #(
        .MAX_BURST (MAX_BURST)
    ) u_burst_counter (
        .clk_i  (ph1),
        .rst_ni (reset),
        .en_i   (ld_gnt),
        .clr_i  (burst_clr),
        .term_o (burst_term)
    );

    // HOLDOFF always returns to CPU first, so the loader needs a further boundary to re-enter.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_CPU: begin
                if (bus.ld_req && bus.cpu_boundary) state_d = ARB_LD;
            end
            ARB_LD: begin
                if (!bus.ld_req)     state_d = ARB_CPU;
                else if (burst_term) state_d = ARB_HOLDOFF;
            end
            ARB_HOLDOFF: begin
                if (bus.cpu_boundary) state_d = ARB_CPU;
            end
            default: state_d = ARB_CPU;
        endcase
    end

    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            state_q    <= ARB_CPU;
            owner_q    <= 1'b0;
            ld_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= (state_d == ARB_LD);
            if (ld_gnt && !bus.ld_we) begin
                ld_rdata_q <= bus.mem_rdata;
            end
        end
    end

    // A dropped request in the loader state must not leave a stray write on the port.
    always_comb begin
        mux_adr   = bus.cpu_adr;
        mux_wdata = bus.cpu_wdata;
        mux_we    = bus.cpu_we;
        if (owner_q) begin
            mux_adr   = bus.ld_adr;
            mux_wdata = bus.ld_wdata;
            mux_we    = bus.ld_we && bus.ld_req;
        end
    end

    assign bus.mem_adr   = mux_adr;
    assign bus.mem_wdata = mux_wdata;
    assign bus.mem_we    = mux_we;
    assign bus.cpu_rdata = bus.mem_rdata;
    assign bus.cpu_stall = owner_q;
    assign bus.owner     = owner_q;
    assign bus.ld_gnt    = ld_gnt;
    assign bus.ld_rdata  = ld_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 256x8 memory on the port.
// Memory initialises to addr ^ 0x1C while reset is low, so 0x20 reads 0x3C.
module tb_mem_port_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(8), .DW(8)) bus ();

    mem_port_arbiter #(
        .AW        (8),
        .DW        (8),
        .MAX_BURST (4)
    ) dut (
        .ph1   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    logic [7:0] mem [256];
    assign bus.mem_rdata = mem[bus.mem_adr];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h1C;
        end else if (bus.mem_we) begin
            mem[bus.mem_adr] <= bus.mem_wdata;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int grants;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs six cycles with boundary low, counting granted beats of a write burst.
    task automatic run_burst(input logic [7:0] base, output int n);
        n = 0;
        bus.cpu_boundary = 1'b0;
        for (int c = 0; c < 6; c++) begin
            bus.ld_adr   = base + 8'(n);
            bus.ld_wdata = 8'h80 + base[3:0] + 8'(n);
            #1;
            if (bus.ld_gnt) n++;
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.cpu_adr      = 8'h99;
        bus.cpu_we       = 1'b1;
        bus.cpu_wdata    = 8'h00;
        bus.cpu_boundary = 1'b0;
        bus.ld_req       = 1'b1;
        bus.ld_we        = 1'b0;
        bus.ld_adr       = 8'h00;
        bus.ld_wdata     = 8'h00;

        // Reset state with loader already requesting
        repeat (3) tick();
        check("rst_owner",    32'(bus.owner),     32'h0);
        check("rst_gnt",      32'(bus.ld_gnt),    32'h0);
        check("rst_stall",    32'(bus.cpu_stall), 32'h0);
        check("rst_ld_rdata", 32'(bus.ld_rdata),  32'h0);
        check("rst_mem_we",   32'(bus.mem_we),    32'h1);
        check("rst_mem_adr",  32'(bus.mem_adr),   32'h99);
        bus.cpu_we = 1'b0;
        rst_n      = 1'b1;
        repeat (3) begin
            tick();
            check("post_rst_no_gnt", 32'(bus.ld_gnt), 32'h0);
        end

        // Two loader writes after a boundary
        bus.cpu_adr      = 8'h00;
        bus.ld_we        = 1'b1;
        bus.ld_adr       = 8'h10;
        bus.ld_wdata     = 8'hA5;
        bus.cpu_boundary = 1'b1;
        #1;
        check("wr_boundary_no_gnt", 32'(bus.ld_gnt), 32'h0);
        tick();
        bus.cpu_boundary = 1'b0;
        #1;
        check("wr_beat0_gnt",   32'(bus.ld_gnt),    32'h1);
        check("wr_beat0_stall", 32'(bus.cpu_stall), 32'h1);
        check("wr_beat0_adr",   32'(bus.mem_adr),   32'h10);
        check("wr_beat0_we",    32'(bus.mem_we),    32'h1);
        tick();
        bus.ld_adr   = 8'h11;
        bus.ld_wdata = 8'h5A;
        #1;
        check("wr_beat1_gnt",   32'(bus.ld_gnt),    32'h1);
        check("wr_beat1_wdata", 32'(bus.mem_wdata), 32'h5A);
        tick();
        bus.ld_req = 1'b0;
        #1;
        check("wr_drop_gnt",   32'(bus.ld_gnt),    32'h0);
        check("wr_drop_stall", 32'(bus.cpu_stall), 32'h1);
        check("wr_drop_we",    32'(bus.mem_we),    32'h0);
        tick();
        check("wr_release_stall", 32'(bus.cpu_stall), 32'h0);
        check("wr_release_owner", 32'(bus.owner),     32'h0);
        check("wr_mem10", 32'(mem[8'h10]), 32'hA5);
        check("wr_mem11", 32'(mem[8'h11]), 32'h5A);

        // Loader read of 0x20
        bus.ld_req       = 1'b1;
        bus.ld_we        = 1'b0;
        bus.ld_adr       = 8'h20;
        bus.cpu_adr      = 8'h20;
        bus.cpu_boundary = 1'b1;
        #1;
        check("rd_cpu_rdata", 32'(bus.cpu_rdata), 32'h3C);
        tick();
        bus.cpu_boundary = 1'b0;
        #1;
        check("rd_gnt", 32'(bus.ld_gnt),  32'h1);
        check("rd_adr", 32'(bus.mem_adr), 32'h20);
        tick();
        bus.ld_req = 1'b0;
        bus.ld_adr = 8'h21;
        #1;
        check("rd_data",      32'(bus.ld_rdata), 32'h3C);
        tick();
        check("rd_data_held", 32'(bus.ld_rdata), 32'h3C);
        check("rd_owner_cpu", 32'(bus.owner),    32'h0);

        // Long request: burst limit, holdoff, second burst
        bus.ld_req       = 1'b1;
        bus.ld_we        = 1'b1;
        bus.cpu_boundary = 1'b1;
        #1;
        tick();
        run_burst(8'h40, grants);
        check("burst1_grants", 32'(grants),         32'd4);
        check("holdoff_owner", 32'(bus.owner),      32'h0);
        check("holdoff_stall", 32'(bus.cpu_stall),  32'h0);
        bus.cpu_boundary = 1'b1;
        #1;
        check("holdoff_boundary_no_gnt", 32'(bus.ld_gnt), 32'h0);
        tick();
        bus.cpu_boundary = 1'b0;
        #1;
        check("holdoff_to_cpu_no_gnt", 32'(bus.ld_gnt), 32'h0);
        check("holdoff_to_cpu_owner",  32'(bus.owner),  32'h0);
        tick();
        bus.cpu_boundary = 1'b1;
        #1;
        tick();
        run_burst(8'h44, grants);
        check("burst2_grants", 32'(grants),      32'd4);
        check("burst_mem40",   32'(mem[8'h40]),  32'h80);
        check("burst_mem43",   32'(mem[8'h43]),  32'h83);
        check("burst_mem44",   32'(mem[8'h44]),  32'h84);
        check("burst_mem47",   32'(mem[8'h47]),  32'h87);
        bus.ld_req       = 1'b0;
        bus.cpu_boundary = 1'b1;
        #1;
        tick();

        // No boundary: CPU keeps the port and writes uninterrupted
        bus.ld_req       = 1'b1;
        bus.ld_we        = 1'b0;
        bus.ld_adr       = 8'h30;
        bus.cpu_adr      = 8'h30;
        bus.cpu_we       = 1'b1;
        bus.cpu_wdata    = 8'h77;
        bus.cpu_boundary = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("nob_no_gnt", 32'(bus.ld_gnt), 32'h0);
            check("nob_mem_we", 32'(bus.mem_we), 32'h1);
            tick();
        end
        bus.cpu_we       = 1'b0;
        bus.cpu_boundary = 1'b1;
        #1;
        tick();
        bus.cpu_boundary = 1'b0;
        #1;
        check("nob_gnt_after_boundary", 32'(bus.ld_gnt), 32'h1);
        tick();
        bus.ld_req = 1'b0;
        #1;
        check("nob_cpu_write_seen", 32'(bus.ld_rdata), 32'h77);
        check("nob_mem30",          32'(mem[8'h30]),   32'h77);
        tick();

        // Reset during a loader write beat
        bus.ld_req       = 1'b1;
        bus.ld_we        = 1'b1;
        bus.ld_adr       = 8'h50;
        bus.ld_wdata     = 8'hEE;
        bus.cpu_boundary = 1'b1;
        #1;
        tick();
        bus.cpu_boundary = 1'b0;
        #1;
        check("mid_rst_pre_we", 32'(bus.mem_we), 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_we",    32'(bus.mem_we),    32'h0);
        check("mid_rst_owner", 32'(bus.owner),     32'h0);
        check("mid_rst_stall", 32'(bus.cpu_stall), 32'h0);
        check("mid_rst_gnt",   32'(bus.ld_gnt),    32'h0);
        #1;
        rst_n = 1'b1;
        tick();
        check("mid_rst_no_regrant", 32'(bus.ld_gnt), 32'h0);
        check("mid_rst_mem50",      32'(mem[8'h50]), 32'h50 ^ 32'h1C);
        bus.cpu_boundary = 1'b1;
        #1;
        tick();
        run_burst(8'h60, grants);
        check("mid_rst_full_burst", 32'(grants), 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
